dm_store_buffer: RTL

- Posted-write FIFO between the MEM pipeline stage and the data memory.
- Queues stores (word/half/byte, with PC for the write trace) from the MEM stage and drains them into the data memory write port one per cycle.
- Flags loads that target a word still pending in the buffer, so the hazard unit can stall.
- Rejects misaligned stores and reports them.

---
 rtl/dm_store_buffer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/dm_store_buffer.sv
// ---------------------------------------------------------------------------
// dm_store_buffer
//
// Posted-write FIFO that sits between the MEM stage and the data memory.
// Stores (word/half/byte plus the PC, for the write trace) are queued and
// drained into the data memory write port at most one per cycle. Loads whose
// word index hits a pending store are flagged so the hazard unit can stall.
// Misaligned stores are dropped and reported with a one-cycle pulse.
//
// Optional feature macro: STORE_BUF_FWD_EN
//   When defined, a word load whose youngest matching entry is a word store
//   gets that entry's data forwarded instead of stalling.
//
// Parameters:
//   DEPTH  number of buffered stores (power of two, >= 2)
//   AW     word-index width; the word index is addr[AW+1:2]
//
// Ports:
//   clk, rst            clock (rising edge), async active-low reset
//   st_valid/addr/align/wd/pc, st_ready   store request from MEM stage
//   st_misalign         registered pulse: previous-cycle store rejected
//   ld_valid/addr/align load probe from MEM stage
//   ld_stall            load must wait (combinational)
//   ld_fwd_valid/data   forwarded load data (feature macro only, else 0)
//   drain_en            data memory write port granted this cycle
//   dm_we/addr/align/wd/pc   head entry towards the data memory
//   empty               no entries pending
//
// Handshake: a store is taken on a rising edge when st_valid & st_ready and
// the address is aligned for its width; st_ready never depends on st_valid
// or on alignment. dm_we is the drain strobe; the head entry retires on the
// edge where dm_we is high.
// ---------------------------------------------------------------------------
module dm_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [1:0]  st_align,
    input  logic [31:0] st_wd,
    input  logic [31:0] st_pc,
    output logic        st_ready,
    output logic        st_misalign,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    input  logic [1:0]  ld_align,
    output logic        ld_stall,
    output logic        ld_fwd_valid,
    output logic [31:0] ld_fwd_data,
    input  logic        drain_en,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [1:0]  dm_align,
    output logic [31:0] dm_wd,
    output logic [31:0] dm_pc,
    output logic        empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    // Entry storage. Contents are don't-care after reset, so no reset here.
    logic [31:0] ent_addr_q  [DEPTH];
    logic [1:0]  ent_align_q [DEPTH];
    logic [31:0] ent_wd_q    [DEPTH];
    logic [31:0] ent_pc_q    [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          misalign_q, misalign_d;

    logic aligned;
    logic push;
    logic hit;

    // ------------------------------------------------------------------
    // Alignment check. Reserved encoding 11 is treated as a word.
    // ------------------------------------------------------------------
    always_comb begin
        aligned = 1'b0;
        case (st_align)
            2'b01:   aligned = ~st_addr[0];
            2'b10:   aligned = 1'b1;
            default: aligned = (st_addr[1:0] == 2'b00);
        endcase
    end

    assign empty    = (count_q == '0);
    assign dm_we    = ~empty & drain_en;
    // A full buffer still accepts when the head retires on the same edge.
    assign st_ready = (count_q < CW'(DEPTH)) | dm_we;
    assign push     = st_valid & st_ready & aligned;

    assign dm_addr  = ent_addr_q[rd_ptr_q];
    assign dm_align = ent_align_q[rd_ptr_q];
    assign dm_wd    = ent_wd_q[rd_ptr_q];
    assign dm_pc    = ent_pc_q[rd_ptr_q];

    assign st_misalign = misalign_q;

    // ------------------------------------------------------------------
    // Next-state for pointers, occupancy and the reject pulse.
    // ------------------------------------------------------------------
    always_comb begin
        rd_ptr_d   = rd_ptr_q + PW'(dm_we);
        wr_ptr_d   = wr_ptr_q + PW'(push);
        count_d    = count_q + CW'(push) - CW'(dm_we);
        misalign_d = st_valid & ~aligned;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr_q[wr_ptr_q]  <= st_addr;
            ent_align_q[wr_ptr_q] <= st_align;
            ent_wd_q[wr_ptr_q]    <= st_wd;
            ent_pc_q[wr_ptr_q]    <= st_pc;
        end
    end

    // ------------------------------------------------------------------
    // Load hazard scan. Offsets walk from the head (oldest) towards the
    // tail, so the last match seen is the youngest one. Offsets at or past
    // count are not live; the pointer add wraps naturally modulo DEPTH.
    // ------------------------------------------------------------------
`ifdef STORE_BUF_FWD_EN
    logic        yng_word;
    logic [31:0] yng_wd;
    logic        fwd_ok;
`endif
    logic [PW-1:0] scan_idx;

    always_comb begin
        hit      = 1'b0;
        scan_idx = '0;
`ifdef STORE_BUF_FWD_EN
        yng_word = 1'b0;
        yng_wd   = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = rd_ptr_q + PW'(i);
            if ((CW'(i) < count_q) &&
                (ent_addr_q[scan_idx][AW+1:2] == ld_addr[AW+1:2])) begin
                hit = 1'b1;
`ifdef STORE_BUF_FWD_EN
                yng_word = (ent_align_q[scan_idx] == 2'b00) |
                           (ent_align_q[scan_idx] == 2'b11);
                yng_wd   = ent_wd_q[scan_idx];
`endif
            end
        end
    end

`ifdef STORE_BUF_FWD_EN
    assign fwd_ok       = ld_valid & hit & (ld_align == 2'b00) & yng_word;
    assign ld_fwd_valid = fwd_ok;
    assign ld_fwd_data  = fwd_ok ? yng_wd : 32'h0;
    assign ld_stall     = ld_valid & hit & ~fwd_ok;

    logic unused_ld;
    assign unused_ld = ^{ld_addr[31:AW+2], ld_addr[1:0]};
`else
    assign ld_fwd_valid = 1'b0;
    assign ld_fwd_data  = 32'h0;
    assign ld_stall     = ld_valid & hit;

    // Load width only matters for forwarding.
    logic unused_ld;
    assign unused_ld = ^{ld_addr[31:AW+2], ld_addr[1:0], ld_align};
`endif

endmodule
